// File: rtl/tune_sequencer_pkg.sv
// Shared types for the tune sequencer: FSM states, note periods (us) and the default tune table.
package tune_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StPlay,
      StGap,
      StDone
   } state_e;

   localparam int unsigned NOTE_C4 = 3822;
   localparam int unsigned NOTE_A4 = 2273;
   localparam int unsigned NOTE_C5 = 1911;
   localparam int unsigned REST    = 0;

   localparam int unsigned ROM_DUR_W = 16;

   typedef struct packed {
      logic [31:0]          period;
      logic [ROM_DUR_W-1:0] dur;
   } note_t;

   // Entry 8 is the end marker (dur == 0); everything past it reads as a marker too.
   function automatic note_t tune_rom(input int unsigned idx);
      note_t n;
      n.period = '0;
      n.dur    = '0;
      case (idx)
         0: begin n.period = NOTE_A4; n.dur = 2; end
         1: begin n.period = NOTE_C4; n.dur = 1; end
         2: begin n.period = REST;    n.dur = 1; end
         3: begin n.period = NOTE_C5; n.dur = 1; end
         4: begin n.period = NOTE_A4; n.dur = 1; end
         5: begin n.period = NOTE_C4; n.dur = 2; end
         6: begin n.period = REST;    n.dur = 1; end
         7: begin n.period = NOTE_C5; n.dur = 1; end
         default: ;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/tune_sequencer_if.sv
// Control/status bundle between a player controller (master) and tune_sequencer (slave).
interface tune_sequencer_if #(
   parameter int unsigned IDX_W = 4
);
   logic             start;
   logic             stop;
   logic [31:0]      period;
   logic             tone_en;
   logic [IDX_W-1:0] note_idx;
   logic             busy;
   logic             done;

   modport master (
      output start, stop,
      input  period, tone_en, note_idx, busy, done
   );

   modport slave (
      input  start, stop,
      output period, tone_en, note_idx, busy, done
   );
endinterface

// File: rtl/tune_sequencer_ms_ticker.sv
// Millisecond tick generator: one-cycle tick every CLK_MHZ*1000 cycles; clr restarts the count.
module ms_ticker #(
   parameter int unsigned CLK_MHZ = 12
) (
   input  logic CLK,
   input  logic RST,
   input  logic clr,
   output logic tick
);
   localparam int unsigned MS_CYCLES = CLK_MHZ * 1000;
   localparam int unsigned CNT_W     = $clog2(MS_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MS_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign tick = (cnt_q == CNT_MAX);

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clr || tick) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/tune_sequencer.sv
// Steps through tune_rom, presenting each note's period and gate for its duration.
// Optional TUNE_LOOP_EN: repeat the tune forever instead of stopping in DONE.
module tune_sequencer
   import tune_pkg::*;
#(
   parameter int unsigned CLK_MHZ = 12,
   parameter int unsigned N_NOTES = 16,
   parameter int unsigned DUR_W   = 16,
   parameter int unsigned GAP_MS  = 20
) (
   input  logic             CLK,
   input  logic             RST,
   tune_sequencer_if.slave  bus
);
   localparam int unsigned IDX_W = $clog2(N_NOTES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NOTES - 1);
   localparam logic [DUR_W-1:0] GAP_LAST = DUR_W'(GAP_MS - 1);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [31:0]      period_q, period_d;
   logic             tone_en_q, tone_en_d;
   logic [DUR_W-1:0] dur_q, dur_d;
   logic [DUR_W-1:0] cnt_q, cnt_d;
   logic             tick, clr, end_hit, advance;
   logic             play_done, gap_done;
   note_t            entry;
   logic [DUR_W-1:0] entry_dur;

   assign entry     = tune_rom(32'(idx_q));
   assign entry_dur = DUR_W'(entry.dur);

   // cnt_q counts whole ms elapsed in the current PLAY/GAP; leaving on the last tick
   // keeps it within dur_q-1, so it can never overflow.
   assign play_done = tick && (cnt_q == dur_q - 1'b1);
   assign gap_done  = tick && (cnt_q == GAP_LAST);

   ms_ticker #(
      .CLK_MHZ(CLK_MHZ)
   ) u_ticker (
      .CLK (CLK),
      .RST (RST),
      .clr (clr),
      .tick(tick)
   );

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      period_d  = period_q;
      tone_en_d = tone_en_q;
      dur_d     = dur_q;
      cnt_d     = tick ? cnt_q + 1'b1 : cnt_q;
      end_hit   = 1'b0;
      advance   = 1'b0;

      unique case (state_q)
         StIdle, StDone: begin
            if (bus.start) begin
               state_d = StLoad;
               idx_d   = '0;
            end
         end
         StLoad: begin
            if (entry_dur == '0) begin
               end_hit = 1'b1;
            end else begin
               state_d   = StPlay;
               period_d  = entry.period;
               tone_en_d = (entry.period != '0);
               dur_d     = entry_dur;
            end
         end
         StPlay: begin
            if (play_done) begin
               tone_en_d = 1'b0;
               if (GAP_MS != 0) begin
                  state_d = StGap;
               end else begin
                  advance = 1'b1;
               end
            end
         end
         StGap: begin
            if (gap_done) begin
               advance = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase

      if (advance) begin
         if (idx_q == LAST_IDX) begin
            end_hit = 1'b1;
         end else begin
            state_d = StLoad;
            idx_d   = idx_q + 1'b1;
         end
      end

      if (end_hit) begin
`ifdef TUNE_LOOP_EN
         state_d = StLoad;
         idx_d   = '0;
`else
         state_d   = StDone;
         period_d  = '0;
         tone_en_d = 1'b0;
`endif
      end

      // stop overrides everything, including a simultaneous start
      if (bus.stop) begin
         state_d   = StIdle;
         period_d  = '0;
         tone_en_d = 1'b0;
         idx_d     = '0;
      end

      clr = ((state_d == StPlay) && (state_q != StPlay)) ||
            ((state_d == StGap) && (state_q != StGap));
      if (clr) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= StIdle;
         idx_q     <= '0;
         period_q  <= '0;
         tone_en_q <= 1'b0;
         dur_q     <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         period_q  <= period_d;
         tone_en_q <= tone_en_d;
         dur_q     <= dur_d;
         cnt_q     <= cnt_d;
      end
   end

   assign bus.period   = period_q;
   assign bus.tone_en  = tone_en_q;
   assign bus.note_idx = idx_q;
   assign bus.busy     = (state_q == StLoad) || (state_q == StPlay) || (state_q == StGap);
   assign bus.done     = (state_q == StDone);
endmodule
